// File: rtl/brnch_tgt_queue.sv
// In-order branch target queue: accepts up to two targets per fetch group,
// hands them out one per cycle over valid/ready, and throttles fetch near full.
module brnch_tgt_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          enq_vld,
    input  logic [3:0]    brnch_pc_sel_from_bhndlr,
    input  logic [15:0]   brnch_addr_pc0,
    input  logic [15:0]   brnch_addr_pc1,
    input  logic          deq_rdy,
    output logic          deq_vld,
    output logic [15:0]   deq_tgt,
    output logic [1:0]    deq_slot,
    output logic          enq_stall,
    output logic [AW:0]   cnt,
    output logic          ovf_err,
    output logic          sel_err
);

    logic [15:0]   tgt_mem [DEPTH];
    logic [1:0]    slot_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   cnt_reg;
    logic          ovf_err_reg;
    logic          sel_err_reg;

    logic [2:0]    pop;
    logic [1:0]    hi_slot;
    logic [1:0]    lo_slot;
    logic [1:0]    n_req;
    logic [1:0]    n_acc;
    logic          sel_bad;
    logic          ovf;
    logic [AW:0]   free_cnt;
    logic [AW:0]   n_ext;
    logic          deq_fire;
    logic [AW-1:0] wr_ptr_inc;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   cnt_next;

    // hi_slot belongs to the highest set mask bit (oldest branch), lo_slot to the lowest.
    always_comb begin
        hi_slot = 2'd0;
        lo_slot = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (brnch_pc_sel_from_bhndlr[b]) hi_slot = 2'(3 - b);
        end
        for (int b = 3; b >= 0; b--) begin
            if (brnch_pc_sel_from_bhndlr[b]) lo_slot = 2'(3 - b);
        end
    end

    always_comb begin
        pop = 3'(brnch_pc_sel_from_bhndlr[0]) + 3'(brnch_pc_sel_from_bhndlr[1])
            + 3'(brnch_pc_sel_from_bhndlr[2]) + 3'(brnch_pc_sel_from_bhndlr[3]);
        sel_bad  = enq_vld && (pop >= 3'd3);
        n_req    = (enq_vld && (pop <= 3'd2)) ? pop[1:0] : 2'd0;
        free_cnt = (AW+1)'(DEPTH) - cnt_reg;
        n_ext    = {{(AW-1){1'b0}}, n_req};
        // Space is judged against occupancy before this cycle's dequeue.
        ovf      = (n_req != 2'd0) && (n_ext > free_cnt);
        n_acc    = ovf ? 2'd0 : n_req;
        deq_fire = (cnt_reg != '0) && deq_rdy;
        wr_ptr_inc  = wr_ptr_reg + AW'(1);
        wr_ptr_next = wr_ptr_reg + {{(AW-2){1'b0}}, n_acc};
        rd_ptr_next = rd_ptr_reg + {{(AW-1){1'b0}}, deq_fire};
        cnt_next    = cnt_reg + {{(AW-1){1'b0}}, n_acc} - {{AW{1'b0}}, deq_fire};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            ovf_err_reg <= 1'b0;
            sel_err_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            ovf_err_reg <= 1'b0;
            sel_err_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            cnt_reg     <= cnt_next;
            ovf_err_reg <= ovf;
            sel_err_reg <= sel_bad;
        end
    end

    // Each entry owns its write port; the two writes of a pair never collide.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tgt_mem[gi]  <= '0;
                    slot_mem[gi] <= '0;
                end else if (!flush) begin
                    if ((n_acc != 2'd0) && (wr_ptr_reg == AW'(gi))) begin
                        tgt_mem[gi]  <= brnch_addr_pc0;
                        slot_mem[gi] <= hi_slot;
                    end else if ((n_acc == 2'd2) && (wr_ptr_inc == AW'(gi))) begin
                        tgt_mem[gi]  <= brnch_addr_pc1;
                        slot_mem[gi] <= lo_slot;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        deq_vld   = (cnt_reg != '0);
        deq_tgt   = deq_vld ? tgt_mem[rd_ptr_reg] : 16'd0;
        deq_slot  = deq_vld ? slot_mem[rd_ptr_reg] : 2'd0;
        enq_stall = (cnt_reg > (AW+1)'(DEPTH - 2));
        cnt       = cnt_reg;
        ovf_err   = ovf_err_reg;
        sel_err   = sel_err_reg;
    end

endmodule

// File: tb/tb_brnch_tgt_queue.sv
// Directed bench for brnch_tgt_queue: one task per scenario, inline checks.
module tb_brnch_tgt_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq_vld;
    logic [3:0]  mask;
    logic [15:0] pc0;
    logic [15:0] pc1;
    logic        deq_rdy;
    logic        deq_vld;
    logic [15:0] deq_tgt;
    logic [1:0]  deq_slot;
    logic        enq_stall;
    logic [3:0]  cnt;
    logic        ovf_err;
    logic        sel_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_tgt[$];
    logic [1:0]  exp_slot[$];

    brnch_tgt_queue #(.DEPTH(8), .AW(3)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .enq_vld(enq_vld),
        .brnch_pc_sel_from_bhndlr(mask),
        .brnch_addr_pc0(pc0),
        .brnch_addr_pc1(pc1),
        .deq_rdy(deq_rdy),
        .deq_vld(deq_vld),
        .deq_tgt(deq_tgt),
        .deq_slot(deq_slot),
        .enq_stall(enq_stall),
        .cnt(cnt),
        .ovf_err(ovf_err),
        .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b);
        enq_vld = 1'b1; mask = m; pc0 = a; pc1 = b;
        tick();
        enq_vld = 1'b0; mask = 4'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 0; enq_vld = 0; mask = 0; pc0 = 0; pc1 = 0; deq_rdy = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({deq_vld, deq_tgt, deq_slot, enq_stall, cnt, ovf_err, sel_err} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs got vld=%b tgt=%h slot=%0d stall=%b cnt=%0d ovf=%b sel=%b required all 0",
                     deq_vld, deq_tgt, deq_slot, enq_stall, cnt, ovf_err, sel_err);
        end
        $display("test_reset: cnt=%0d vld=%b", cnt, deq_vld);
    endtask

    task automatic test_single();
        enq(4'b0100, 16'h0012, 16'h0000);
        checks++;
        if ({deq_vld, deq_tgt, deq_slot, cnt} !== {1'b1, 16'h0012, 2'd1, 4'd1}) begin
            failures++;
            $display("FAIL single_head got vld=%b tgt=%h slot=%0d cnt=%0d required 1 0012 1 1",
                     deq_vld, deq_tgt, deq_slot, cnt);
        end
        deq_rdy = 1'b1; tick(); deq_rdy = 1'b0;
        checks++;
        if ({deq_vld, deq_tgt, deq_slot, cnt} !== 23'd0) begin
            failures++;
            $display("FAIL single_drain got vld=%b tgt=%h slot=%0d cnt=%0d required all 0",
                     deq_vld, deq_tgt, deq_slot, cnt);
        end
        $display("test_single: tgt 0012 slot 1 enqueued and drained");
    endtask

    task automatic test_pair();
        enq(4'b1001, 16'h0100, 16'h0200);
        checks++;
        if ({deq_tgt, deq_slot, cnt} !== {16'h0100, 2'd0, 4'd2}) begin
            failures++;
            $display("FAIL pair_first got tgt=%h slot=%0d cnt=%0d required 0100 0 2", deq_tgt, deq_slot, cnt);
        end
        deq_rdy = 1'b1; tick();
        checks++;
        if ({deq_tgt, deq_slot, cnt} !== {16'h0200, 2'd3, 4'd1}) begin
            failures++;
            $display("FAIL pair_second got tgt=%h slot=%0d cnt=%0d required 0200 3 1", deq_tgt, deq_slot, cnt);
        end
        tick(); deq_rdy = 1'b0;
        checks++;
        if (cnt !== 4'd0) begin
            failures++;
            $display("FAIL pair_empty got cnt=%0d required 0", cnt);
        end
        $display("test_pair: 0100/slot0 then 0200/slot3");
    endtask

    task automatic drain_check(input string name);
        deq_rdy = 1'b1;
        while (exp_tgt.size() != 0) begin
            checks++;
            if ({deq_vld, deq_tgt, deq_slot} !== {1'b1, exp_tgt[0], exp_slot[0]}) begin
                failures++;
                $display("FAIL %s_order got vld=%b tgt=%h slot=%0d required 1 %h %0d",
                         name, deq_vld, deq_tgt, deq_slot, exp_tgt[0], exp_slot[0]);
            end
            void'(exp_tgt.pop_front());
            void'(exp_slot.pop_front());
            tick();
        end
        deq_rdy = 1'b0;
        checks++;
        if ({deq_vld, cnt} !== 5'd0) begin
            failures++;
            $display("FAIL %s_empty got vld=%b cnt=%0d required 0 0", name, deq_vld, cnt);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            enq(4'b0101, 16'h1100 + 16'(i), 16'h1200 + 16'(i));
            exp_tgt.push_back(16'h1100 + 16'(i)); exp_slot.push_back(2'd1);
            exp_tgt.push_back(16'h1200 + 16'(i)); exp_slot.push_back(2'd3);
            checks++;
            if ({cnt, enq_stall} !== {4'(2 * i + 2), (i == 3)}) begin
                failures++;
                $display("FAIL fill_%0d got cnt=%0d stall=%b required %0d %b", i, cnt, enq_stall, 2 * i + 2, i == 3);
            end
        end
        enq(4'b1000, 16'hDEAD, 16'h0000);
        checks++;
        if ({ovf_err, cnt, deq_vld} !== {1'b1, 4'd8, 1'b1}) begin
            failures++;
            $display("FAIL full_drop got ovf=%b cnt=%0d vld=%b required 1 8 1", ovf_err, cnt, deq_vld);
        end
        tick();
        checks++;
        if (ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pulse_width got ovf=%b required 0", ovf_err);
        end
        deq_rdy = 1'b1; tick(); deq_rdy = 1'b0;
        void'(exp_tgt.pop_front()); void'(exp_slot.pop_front());
        checks++;
        if ({cnt, enq_stall} !== {4'd7, 1'b1}) begin
            failures++;
            $display("FAIL cnt7_stall got cnt=%0d stall=%b required 7 1", cnt, enq_stall);
        end
        enq(4'b1100, 16'hBAD0, 16'hBAD1);
        checks++;
        if ({ovf_err, cnt} !== {1'b1, 4'd7}) begin
            failures++;
            $display("FAIL cnt7_pair_drop got ovf=%b cnt=%0d required 1 7", ovf_err, cnt);
        end
        enq(4'b0001, 16'h1300, 16'h0000);
        exp_tgt.push_back(16'h1300); exp_slot.push_back(2'd3);
        checks++;
        if ({ovf_err, cnt} !== {1'b0, 4'd8}) begin
            failures++;
            $display("FAIL cnt7_single_accept got ovf=%b cnt=%0d required 0 8", ovf_err, cnt);
        end
        // A same-cycle dequeue must not make room for the enqueue.
        deq_rdy = 1'b1;
        enq(4'b0010, 16'hBAD2, 16'h0000);
        deq_rdy = 1'b0;
        void'(exp_tgt.pop_front()); void'(exp_slot.pop_front());
        checks++;
        if ({ovf_err, cnt} !== {1'b1, 4'd7}) begin
            failures++;
            $display("FAIL full_deq_no_room got ovf=%b cnt=%0d required 1 7", ovf_err, cnt);
        end
        drain_check("full");
        $display("test_full: fill, overflow drops and in-order drain done");
    endtask

    task automatic test_wrap();
        // Pointers sit at 4 here; three enqueue/dequeue pairs move them to 7.
        for (int i = 0; i < 3; i++) begin
            enq(4'b1000, 16'h0050 + 16'(i), 16'h0000);
            deq_rdy = 1'b1; tick(); deq_rdy = 1'b0;
        end
        enq(4'b0011, 16'hAAAA, 16'hBBBB);
        exp_tgt.push_back(16'hAAAA); exp_slot.push_back(2'd2);
        exp_tgt.push_back(16'hBBBB); exp_slot.push_back(2'd3);
        checks++;
        if (cnt !== 4'd2) begin
            failures++;
            $display("FAIL wrap_cnt got cnt=%0d required 2", cnt);
        end
        drain_check("wrap");
        $display("test_wrap: AAAA slot2 then BBBB slot3 across index 7/0");
    endtask

    task automatic test_back_to_back();
        enq(4'b0100, 16'h7001, 16'h0000);
        deq_rdy = 1'b1;
        enq(4'b0010, 16'h7002, 16'h0000);
        deq_rdy = 1'b0;
        checks++;
        if ({cnt, deq_tgt, deq_slot} !== {4'd1, 16'h7002, 2'd2}) begin
            failures++;
            $display("FAIL b2b_enq_deq got cnt=%0d tgt=%h slot=%0d required 1 7002 2", cnt, deq_tgt, deq_slot);
        end
        deq_rdy = 1'b1; tick(); tick(); deq_rdy = 1'b0;
        checks++;
        if (cnt !== 4'd0) begin
            failures++;
            $display("FAIL empty_no_underflow got cnt=%0d required 0", cnt);
        end
        $display("test_back_to_back: simultaneous enq/deq and empty dequeue");
    endtask

    task automatic test_flush();
        enq(4'b1010, 16'h3001, 16'h3002);
        enq(4'b0001, 16'h3003, 16'h0000);
        checks++;
        if (cnt !== 4'd3) begin
            failures++;
            $display("FAIL flush_setup got cnt=%0d required 3", cnt);
        end
        flush = 1'b1; deq_rdy = 1'b1;
        enq(4'b1100, 16'h3004, 16'h3005);
        flush = 1'b0; deq_rdy = 1'b0;
        checks++;
        if ({cnt, deq_vld, deq_tgt, ovf_err, sel_err} !== 23'd0) begin
            failures++;
            $display("FAIL flush_clear got cnt=%0d vld=%b tgt=%h ovf=%b sel=%b required all 0",
                     cnt, deq_vld, deq_tgt, ovf_err, sel_err);
        end
        $display("test_flush: cnt 3 flushed with concurrent enq/deq");
    endtask

    task automatic test_sel_err();
        enq(4'b0100, 16'h4001, 16'h0000);
        enq(4'b1110, 16'h4002, 16'h4003);
        checks++;
        if ({sel_err, ovf_err, cnt, deq_tgt} !== {1'b1, 1'b0, 4'd1, 16'h4001}) begin
            failures++;
            $display("FAIL sel_err_pulse got sel=%b ovf=%b cnt=%0d tgt=%h required 1 0 1 4001",
                     sel_err, ovf_err, cnt, deq_tgt);
        end
        enq(4'b1111, 16'h4004, 16'h4005);
        tick();
        checks++;
        if ({sel_err, cnt} !== {1'b0, 4'd1}) begin
            failures++;
            $display("FAIL sel_err_width got sel=%b cnt=%0d required 0 1", sel_err, cnt);
        end
        $display("test_sel_err: illegal masks rejected");
    endtask

    task automatic test_async_rst();
        enq(4'b1001, 16'h5001, 16'h5002);
        enq(4'b0110, 16'h5003, 16'h5004);
        checks++;
        if ({cnt, deq_tgt} !== {4'd5, 16'h4001}) begin
            failures++;
            $display("FAIL rst_setup got cnt=%0d tgt=%h required 5 4001", cnt, deq_tgt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({deq_vld, deq_tgt, deq_slot, enq_stall, cnt, ovf_err, sel_err} !== 26'd0) begin
            failures++;
            $display("FAIL async_rst got vld=%b tgt=%h slot=%0d stall=%b cnt=%0d required all 0",
                     deq_vld, deq_tgt, deq_slot, enq_stall, cnt);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({deq_vld, cnt} !== 5'd0) begin
            failures++;
            $display("FAIL post_rst got vld=%b cnt=%0d required 0 0", deq_vld, cnt);
        end
        $display("test_async_rst: mid-cycle reset at cnt 5");
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_full();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_sel_err();
        test_async_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running required finished");
        $fatal(1, "timeout");
    end

endmodule
